ldtu_data32_lane_rx: RTL and testbench

Back-end receiver for the four 32-bit LiteDTU output lanes, the counterpart of the lane multiplexer. It takes deserialized words from lanes 0–3 and acquires word lock on the idle patterns. In normal mode it extracts DTU data from lane 0 and reports calibration-idle periods; in test mode it forwards the four ATU words. It counts idle-pattern violations on lanes 1–3. It sits in the FPGA readout and emulation path, after the per-lane deserializers.

---
 rtl/ldtu_data32_lane_rx.sv | 151 +++++++++++++++
 tb/tb_ldtu_data32_lane_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ldtu_data32_lane_rx.sv
// Receiver for the four 32-bit LiteDTU output lanes: word lock on idle patterns,
// DTU data extraction from lane 0 in normal mode, ATU forwarding in test mode.
module ldtu_data32_lane_rx #(
    parameter int          Nbits_32       = 32,
    parameter logic [31:0] idle_patternEA = 32'hEAAAAAAA,
    parameter logic [31:0] idle_pattern5A = 32'h5A5A5A5A,
    parameter int          LOCK_COUNT     = 4,
    parameter int          UNLOCK_COUNT   = 3,
    parameter int          ERR_CNT_W      = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 TEST_ENABLE,
    input  logic                 WORD_VALID,
    input  logic [Nbits_32-1:0]  LANE0,
    input  logic [Nbits_32-1:0]  LANE1,
    input  logic [Nbits_32-1:0]  LANE2,
    input  logic [Nbits_32-1:0]  LANE3,
    input  logic                 ERR_CLR,
    output logic [Nbits_32-1:0]  DATA_OUT,
    output logic                 DATA_VALID,
    output logic [Nbits_32-1:0]  ATU_OUT_0,
    output logic [Nbits_32-1:0]  ATU_OUT_1,
    output logic [Nbits_32-1:0]  ATU_OUT_2,
    output logic [Nbits_32-1:0]  ATU_OUT_3,
    output logic                 ATU_VALID,
    output logic                 LOCKED,
    output logic                 CAL_IDLE,
    output logic [ERR_CNT_W-1:0] IDLE_ERR_CNT
);

    typedef enum logic {ST_HUNT = 1'b0, ST_LOCKED = 1'b1} state_t;

    localparam int SYNC_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam int BAD_W  = (UNLOCK_COUNT > 1) ? $clog2(UNLOCK_COUNT) : 1;
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(LOCK_COUNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_COUNT - 1);
    localparam logic [Nbits_32-1:0] PAT_EA = idle_patternEA[Nbits_32-1:0];
    localparam logic [Nbits_32-1:0] PAT_5A = idle_pattern5A[Nbits_32-1:0];

    state_t              state_reg;
    logic [SYNC_W-1:0]   sync_cnt_reg;
    logic [BAD_W-1:0]    bad_cnt_reg;
    logic                prev_mode_reg;
    logic [Nbits_32-1:0] atu_reg [4];
    logic [Nbits_32-1:0] lane_arr [4];

    logic upper_idle;
    logic sync_match;
    logic mode_change;
    logic bad_word;

    assign lane_arr[0] = LANE0;
    assign lane_arr[1] = LANE1;
    assign lane_arr[2] = LANE2;
    assign lane_arr[3] = LANE3;

    assign upper_idle  = (LANE1 == PAT_5A) && (LANE2 == PAT_5A) && (LANE3 == PAT_5A);
    assign sync_match  = upper_idle && (LANE0 == (TEST_ENABLE ? PAT_5A : PAT_EA));
    assign mode_change = (TEST_ENABLE != prev_mode_reg);
    // A word blocked by a mode change is not processed, so it cannot be bad either.
    assign bad_word    = WORD_VALID && !mode_change && (state_reg == ST_LOCKED)
                         && !TEST_ENABLE && !upper_idle;

    assign LOCKED    = (state_reg == ST_LOCKED);
    assign ATU_OUT_0 = atu_reg[0];
    assign ATU_OUT_1 = atu_reg[1];
    assign ATU_OUT_2 = atu_reg[2];
    assign ATU_OUT_3 = atu_reg[3];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_atu
            always_ff @(posedge CLK) begin
                if (!RST) begin
                    atu_reg[gi] <= '0;
                end else if (WORD_VALID && !mode_change && TEST_ENABLE
                             && (state_reg == ST_LOCKED)) begin
                    atu_reg[gi] <= lane_arr[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg     <= ST_HUNT;
            sync_cnt_reg  <= '0;
            bad_cnt_reg   <= '0;
            prev_mode_reg <= TEST_ENABLE;
            DATA_OUT      <= '0;
            DATA_VALID    <= 1'b0;
            ATU_VALID     <= 1'b0;
            CAL_IDLE      <= 1'b0;
            IDLE_ERR_CNT  <= '0;
        end else begin
            prev_mode_reg <= TEST_ENABLE;
            DATA_VALID    <= 1'b0;
            ATU_VALID     <= 1'b0;

            if (ERR_CLR) begin
                IDLE_ERR_CNT <= '0;
            end else if (bad_word && (IDLE_ERR_CNT != {ERR_CNT_W{1'b1}})) begin
                IDLE_ERR_CNT <= IDLE_ERR_CNT + ERR_CNT_W'(1);
            end

            if (mode_change) begin
                state_reg    <= ST_HUNT;
                sync_cnt_reg <= '0;
                bad_cnt_reg  <= '0;
                CAL_IDLE     <= 1'b0;
            end else if (WORD_VALID) begin
                case (state_reg)
                    ST_HUNT: begin
                        if (!sync_match) begin
                            sync_cnt_reg <= '0;
                        end else if (sync_cnt_reg == SYNC_LAST) begin
                            state_reg    <= ST_LOCKED;
                            sync_cnt_reg <= '0;
                        end else begin
                            sync_cnt_reg <= sync_cnt_reg + SYNC_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (TEST_ENABLE) begin
                            ATU_VALID <= 1'b1;
                        end else if (!upper_idle) begin
                            if (bad_cnt_reg == BAD_LAST) begin
                                state_reg   <= ST_HUNT;
                                bad_cnt_reg <= '0;
                            end else begin
                                bad_cnt_reg <= bad_cnt_reg + BAD_W'(1);
                            end
                        end else begin
                            bad_cnt_reg <= '0;
                            if (LANE0 == PAT_EA) begin
                                CAL_IDLE <= 1'b1;
                            end else begin
                                DATA_OUT   <= LANE0;
                                DATA_VALID <= 1'b1;
                                CAL_IDLE   <= 1'b0;
                            end
                        end
                    end
                    default: state_reg <= ST_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ldtu_data32_lane_rx.sv
// Scoreboard bench for ldtu_data32_lane_rx: expected data/ATU words are queued
// when driven and popped when the strobes appear.
module tb_ldtu_data32_lane_rx;

    localparam logic [31:0] EA = 32'hEAAAAAAA;
    localparam logic [31:0] P5 = 32'h5A5A5A5A;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        TEST_ENABLE = 1'b0;
    logic        WORD_VALID = 1'b0;
    logic [31:0] LANE0 = '0, LANE1 = '0, LANE2 = '0, LANE3 = '0;
    logic        ERR_CLR = 1'b0;
    logic [31:0] DATA_OUT, ATU_OUT_0, ATU_OUT_1, ATU_OUT_2, ATU_OUT_3;
    logic        DATA_VALID, ATU_VALID, LOCKED, CAL_IDLE;
    logic [15:0] IDLE_ERR_CNT;

    logic [31:0] s_data, s_a0, s_a1, s_a2, s_a3;
    logic        s_dv, s_av, s_locked, s_cal;
    logic [1:0]  s_err;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0]  data_q[$];
    logic [127:0] atu_q[$];
    logic [31:0]  last_data = '0;

    always #5 CLK = ~CLK;

    ldtu_data32_lane_rx dut (
        .CLK(CLK), .RST(RST), .TEST_ENABLE(TEST_ENABLE), .WORD_VALID(WORD_VALID),
        .LANE0(LANE0), .LANE1(LANE1), .LANE2(LANE2), .LANE3(LANE3), .ERR_CLR(ERR_CLR),
        .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID),
        .ATU_OUT_0(ATU_OUT_0), .ATU_OUT_1(ATU_OUT_1), .ATU_OUT_2(ATU_OUT_2), .ATU_OUT_3(ATU_OUT_3),
        .ATU_VALID(ATU_VALID), .LOCKED(LOCKED), .CAL_IDLE(CAL_IDLE), .IDLE_ERR_CNT(IDLE_ERR_CNT)
    );

    // Narrow error counter instance, same stimulus, to exercise saturation.
    ldtu_data32_lane_rx #(.ERR_CNT_W(2)) dut_small (
        .CLK(CLK), .RST(RST), .TEST_ENABLE(TEST_ENABLE), .WORD_VALID(WORD_VALID),
        .LANE0(LANE0), .LANE1(LANE1), .LANE2(LANE2), .LANE3(LANE3), .ERR_CLR(ERR_CLR),
        .DATA_OUT(s_data), .DATA_VALID(s_dv),
        .ATU_OUT_0(s_a0), .ATU_OUT_1(s_a1), .ATU_OUT_2(s_a2), .ATU_OUT_3(s_a3),
        .ATU_VALID(s_av), .LOCKED(s_locked), .CAL_IDLE(s_cal), .IDLE_ERR_CNT(s_err)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    // Drive one cycle of lane inputs; returns 1 ns after the edge that consumed them.
    task automatic send(input logic v, input logic [31:0] l0, l1, l2, l3);
        WORD_VALID = v;
        LANE0 = l0; LANE1 = l1; LANE2 = l2; LANE3 = l3;
        @(posedge CLK); #1;
        WORD_VALID = 1'b0;
        ERR_CLR = 1'b0;
    endtask

    task automatic send_data(input logic [31:0] d);
        data_q.push_back(d);
        last_data = d;
        send(1'b1, d, P5, P5, P5);
    endtask

    task automatic send_atu(input logic [31:0] a0, a1, a2, a3);
        atu_q.push_back({a0, a1, a2, a3});
        send(1'b1, a0, a1, a2, a3);
    endtask

    always @(negedge CLK) begin
        if (DATA_VALID) begin
            if (data_q.size() == 0) check_val("data_unexpected", {96'd0, DATA_OUT}, 128'd0);
            else check_val("data_out", {96'd0, DATA_OUT}, {96'd0, data_q.pop_front()});
        end
        if (ATU_VALID) begin
            if (atu_q.size() == 0) check_val("atu_unexpected", {ATU_OUT_0, ATU_OUT_1, ATU_OUT_2, ATU_OUT_3}, 128'd0);
            else check_val("atu_out", {ATU_OUT_0, ATU_OUT_1, ATU_OUT_2, ATU_OUT_3}, atu_q.pop_front());
        end
    end

    initial begin
        // Reset state
        repeat (2) send(1'b0, '0, '0, '0, '0);
        check_val("rst_locked", LOCKED, 0);
        check_val("rst_data_out", DATA_OUT, 0);
        check_val("rst_data_valid", DATA_VALID, 0);
        check_val("rst_atu_out_0", ATU_OUT_0, 0);
        check_val("rst_cal_idle", CAL_IDLE, 0);
        check_val("rst_err_cnt", IDLE_ERR_CNT, 0);
        RST = 1'b1;
        send(1'b0, '0, '0, '0, '0);

        // 3 matches, a data word, then 4 matches: lock only after the final 4
        repeat (3) send(1'b1, EA, P5, P5, P5);
        send(1'b1, 32'h00000011, P5, P5, P5);
        check_val("hunt_interrupted", LOCKED, 0);
        repeat (3) send(1'b1, EA, P5, P5, P5);
        check_val("lock_after_3", LOCKED, 0);
        send(1'b1, EA, P5, P5, P5);
        check_val("lock_after_4", LOCKED, 1);
        check_val("cal_idle_before", CAL_IDLE, 0);
        send(1'b1, EA, P5, P5, P5);
        check_val("cal_idle_set", CAL_IDLE, 1);

        // Data extraction, WORD_VALID gaps, back-to-back words
        send_data(32'h12345678);
        check_val("dv_pulse", DATA_VALID, 1);
        check_val("cal_idle_clr", CAL_IDLE, 0);
        send(1'b0, 32'hDEADBEEF, P5, P5, P5);
        check_val("dv_one_cycle", DATA_VALID, 0);
        send(1'b0, 32'hDEADBEEF, P5, P5, P5);
        check_val("data_hold", DATA_OUT, 32'h12345678);
        for (int i = 0; i < 3; i++) send_data(32'hCAFE0000 + i);

        // Bad words: 2 on lane 2, good, 3 on lane 1
        repeat (2) send(1'b1, 32'hAAAA0001, P5, 32'h0, P5);
        check_val("lock_held_2bad", LOCKED, 1);
        send(1'b1, EA, P5, P5, P5);
        repeat (2) send(1'b1, 32'hAAAA0002, 32'h0, P5, P5);
        check_val("lock_held_2bad_b", LOCKED, 1);
        send(1'b1, 32'hAAAA0003, 32'h0, P5, P5);
        check_val("lock_lost_3bad", LOCKED, 0);
        check_val("err_cnt_5", IDLE_ERR_CNT, 5);
        check_val("err_cnt_sat", s_err, 3);

        // Relock, ERR_CLR coincident with a bad word
        repeat (4) send(1'b1, EA, P5, P5, P5);
        check_val("relock", LOCKED, 1);
        ERR_CLR = 1'b1;
        send(1'b1, EA, P5, P5, 32'h1);
        check_val("err_clr_prio", IDLE_ERR_CNT, 0);
        check_val("err_clr_prio_small", s_err, 0);
        send(1'b1, EA, P5, P5, 32'h1);
        check_val("err_cnt_1", IDLE_ERR_CNT, 1);
        send(1'b1, EA, P5, P5, P5);
        check_val("cal_idle_pre_mode", CAL_IDLE, 1);

        // Switch to test mode: forced HUNT, then lock on all-5A
        TEST_ENABLE = 1'b1;
        send(1'b1, P5, P5, P5, P5);
        check_val("mode_unlock", LOCKED, 0);
        check_val("mode_cal_clr", CAL_IDLE, 0);
        repeat (3) send(1'b1, P5, P5, P5, P5);
        check_val("test_lock_3", LOCKED, 0);
        send(1'b1, P5, P5, P5, P5);
        check_val("test_lock_4", LOCKED, 1);
        send_atu(32'd1, 32'd2, 32'd3, 32'd4);
        check_val("atu_valid", ATU_VALID, 1);
        send_atu(32'd5, 32'd6, 32'd7, 32'd8);
        send(1'b0, 32'h9, 32'h9, 32'h9, 32'h9);
        check_val("atu_valid_low", ATU_VALID, 0);
        check_val("atu_hold", ATU_OUT_0, 5);

        // Back to normal mode
        TEST_ENABLE = 1'b0;
        send(1'b1, EA, P5, P5, P5);
        check_val("mode_back_unlock", LOCKED, 0);
        check_val("err_kept", IDLE_ERR_CNT, 1);
        check_val("data_hold_mode", DATA_OUT, last_data);
        repeat (4) send(1'b1, EA, P5, P5, P5);
        check_val("relock_normal", LOCKED, 1);
        send_data(32'h0BADF00D);

        // Reset with a data word in flight
        RST = 1'b0;
        send(1'b1, 32'h77777777, P5, P5, P5);
        check_val("midrst_data_valid", DATA_VALID, 0);
        check_val("midrst_data_out", DATA_OUT, 0);
        check_val("midrst_locked", LOCKED, 0);
        check_val("midrst_err", IDLE_ERR_CNT, 0);
        check_val("midrst_atu", ATU_OUT_0, 0);
        RST = 1'b1;
        repeat (3) send(1'b0, '0, '0, '0, '0);

        check_val("data_q_empty", data_q.size(), 0);
        check_val("atu_q_empty", atu_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
